// File: rtl/beat_note_timer.sv
// beat_note_timer
// ---------------
// Holds the current note for a programmed number of beats and pulses
// note_done for one cycle when that note ends.
//
// It sits between the song-reading logic, which loads note/duration pairs,
// and the tone generator, which plays note_out while sounding is high.
//
// Ports
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous, active-high; clears all state
//   beat         1-cycle tick from the beat generator (never two in a row)
//   play         level: 1 = run, 0 = pause (beats while paused are dropped)
//   load         start a new note; accepted only while busy = 0
//   note_in      note code captured on an accepted load (0 = rest)
//   duration_in  beat count captured on an accepted load (0 means 2^DUR_W)
//   note_out     registered note being timed, 0 when idle
//   sounding     busy & play (combinational)
//   busy         registered, high while a note is being timed
//   note_done    registered 1-cycle pulse at the end of a note
//   beats_left   remaining beats of the current note, 0 when idle
//   state_dbg_o  current FSM state, exposed for checkers
//
// Handshake: load is a request qualified by busy. A load is accepted in
// exactly the cycles where busy = 0 (including the cycle note_done = 1,
// which makes back-to-back notes gapless). A load while busy = 1 is
// dropped with no side effects. There is no separate acknowledge: the
// accepted load shows up as busy = 1 after the next rising edge.
module beat_note_timer #(
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              beat,
   input  logic              play,
   input  logic              load,
   input  logic [NOTE_W-1:0] note_in,
   input  logic [DUR_W-1:0]  duration_in,
   output logic [NOTE_W-1:0] note_out,
   output logic              sounding,
   output logic              busy,
   output logic              note_done,
   output logic [DUR_W:0]    beats_left,
   output logic              state_dbg_o
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_TIMING = 1'b1
   } state_e;

   // Encoding of duration_in = 0: the full 2^DUR_W beats.
   localparam logic [DUR_W:0] FULL_DURATION = {1'b1, {DUR_W{1'b0}}};
   localparam logic [DUR_W:0] ONE_BEAT      = {{DUR_W{1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [NOTE_W-1:0]   note_q, note_d;
   logic [DUR_W:0]      beats_q, beats_d;
   logic                done_q, done_d;

   logic                beat_taken;

   // Only a beat that arrives while running counts; a paused beat is lost.
   assign beat_taken = beat & play;

   always_comb begin
      state_d = state_q;
      note_d  = note_q;
      beats_d = beats_q;
      done_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // A beat coincident with the load is not counted: the count
            // only starts being decremented from TIMING.
            if (load) begin
               state_d = ST_TIMING;
               note_d  = note_in;
               beats_d = (duration_in == '0) ? FULL_DURATION
                                             : {1'b0, duration_in};
            end
         end

         ST_TIMING: begin
            if (beat_taken) begin
               if (beats_q > ONE_BEAT) begin
                  beats_d = beats_q - ONE_BEAT;
               end else begin
                  // Last beat: drop straight to IDLE so a load in the
                  // note_done cycle is accepted with no gap.
                  state_d = ST_IDLE;
                  note_d  = '0;
                  beats_d = '0;
                  done_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            note_d  = '0;
            beats_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         note_q  <= '0;
         beats_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         note_q  <= note_d;
         beats_q <= beats_d;
         done_q  <= done_d;
      end
   end

   assign busy        = (state_q == ST_TIMING);
   assign sounding    = busy & play;
   assign note_out    = note_q;
   assign beats_left  = beats_q;
   assign note_done   = done_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_beat_note_timer.sv
module tb_beat_note_timer;

   localparam int NW = 6;
   localparam int DW = 6;

   // ---------------- clock / reset block ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset = 1'b1;
   logic          beat = 1'b0;
   logic          play = 1'b0;
   logic          load = 1'b0;
   logic [NW-1:0] note_in = '0;
   logic [DW-1:0] duration_in = '0;
   logic [NW-1:0] note_out;
   logic          sounding;
   logic          busy;
   logic          note_done;
   logic [DW:0]   beats_left;
   logic          state_dbg;

   beat_note_timer #(.NOTE_W(NW), .DUR_W(DW)) dut (
      .clock       (clock),
      .reset       (reset),
      .beat        (beat),
      .play        (play),
      .load        (load),
      .note_in     (note_in),
      .duration_in (duration_in),
      .note_out    (note_out),
      .sounding    (sounding),
      .busy        (busy),
      .note_done   (note_done),
      .beats_left  (beats_left),
      .state_dbg_o (state_dbg)
   );

   int vectors = 0;
   int miscompares = 0;

   // ---------------- reference model ----------------
   // Song-level view: a note either is playing with some beats remaining,
   // or nothing is playing. note_done marks the edge at which a note ran out.
   bit m_playing = 0;
   int m_note = 0;
   int m_left = 0;
   bit m_done = 0;
   bit last_beat = 0;

   task automatic model_edge(bit r, bit ld, bit bt, bit pl, int n, int d);
      if (r) begin
         m_playing = 0; m_note = 0; m_left = 0; m_done = 0;
         return;
      end
      m_done = 0;
      if (!m_playing) begin
         if (ld) begin
            m_playing = 1;
            m_note    = n;
            m_left    = (d == 0) ? (2 ** DW) : d;
         end
      end else if (bt && pl) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_playing = 0;
            m_note    = 0;
            m_done    = 1;
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      check("note_out",   32'(note_out),   32'(m_note));
      check("busy",       32'(busy),       32'(m_playing));
      check("note_done",  32'(note_done),  32'(m_done));
      check("beats_left", 32'(beats_left), 32'(m_left));
      check("sounding",   32'(sounding),   32'(m_playing && play));
   endtask

   // ---------------- driver ----------------
   // One clock cycle: apply inputs, advance the model at the edge,
   // then compare #1 after the edge.
   task automatic cyc(bit r, bit ld, bit bt, bit pl, int n, int d);
      bit b;
      b = r ? bt : (bt && !last_beat);
      reset = r; load = ld; beat = b; play = pl;
      note_in = NW'(n); duration_in = DW'(d);
      @(posedge clock);
      model_edge(r, ld, b, pl, n, d);
      last_beat = b;
      #1;
      check_model();
   endtask

   task automatic idle(int k, bit pl);
      for (int i = 0; i < k; i++) cyc(0, 0, 0, pl, 0, 0);
   endtask

   initial begin
      // Reset held 3 cycles with load and beat high.
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 1, 1, 33, 7);
         check("rst_busy", 32'(busy), 0);
         check("rst_beats", 32'(beats_left), 0);
      end
      idle(2, 1);
      check("post_rst_note", 32'(note_out), 0);

      // Basic note 17 x 3 beats, beats every 8 cycles.
      cyc(0, 1, 0, 1, 17, 3);
      check("basic_load_beats", 32'(beats_left), 3);
      check("basic_load_note", 32'(note_out), 17);
      idle(7, 1);
      cyc(0, 0, 1, 1, 0, 0);
      check("basic_b1", 32'(beats_left), 2);
      idle(7, 1);
      cyc(0, 0, 1, 1, 0, 0);
      check("basic_b2", 32'(beats_left), 1);
      idle(7, 1);
      cyc(0, 0, 1, 1, 0, 0);
      check("basic_done", 32'(note_done), 1);
      check("basic_note0", 32'(note_out), 0);
      idle(1, 1);
      check("basic_done_low", 32'(note_done), 0);
      idle(3, 1);

      // Pause: beats while play = 0 are dropped.
      cyc(0, 1, 0, 1, 12, 2);
      for (int i = 0; i < 2; i++) begin
         idle(7, 0);
         cyc(0, 0, 1, 0, 0, 0);
         check("pause_hold", 32'(beats_left), 2);
         check("pause_silent", 32'(sounding), 0);
      end
      idle(7, 1);
      cyc(0, 0, 1, 1, 0, 0);
      check("pause_b1", 32'(beats_left), 1);
      idle(7, 1);
      cyc(0, 0, 1, 1, 0, 0);
      check("pause_done", 32'(note_done), 1);
      idle(2, 1);

      // Duration 0 means 64 beats; a beat coincident with load is not counted.
      cyc(0, 1, 1, 1, 40, 0);
      check("dur0_load", 32'(beats_left), 64);
      for (int i = 0; i < 63; i++) begin
         idle(2, 1);
         cyc(0, 0, 1, 1, 0, 0);
      end
      check("dur0_not_yet", 32'(note_done), 0);
      check("dur0_last1", 32'(beats_left), 1);
      idle(2, 1);
      cyc(0, 0, 1, 1, 0, 0);
      check("dur0_done", 32'(note_done), 1);
      idle(2, 1);

      // Ignored mid-note load, then back-to-back load in the note_done cycle.
      cyc(0, 1, 0, 1, 20, 2);
      idle(3, 1);
      cyc(0, 1, 0, 1, 5, 9);
      check("ign_note", 32'(note_out), 20);
      check("ign_beats", 32'(beats_left), 2);
      idle(3, 1);
      cyc(0, 0, 1, 1, 0, 0);
      idle(3, 1);
      cyc(0, 0, 1, 1, 0, 0);
      check("b2b_done", 32'(note_done), 1);
      check("b2b_free", 32'(busy), 0);
      cyc(0, 1, 0, 1, 9, 1);
      check("b2b_note", 32'(note_out), 9);
      check("b2b_busy", 32'(busy), 1);
      check("b2b_done_low", 32'(note_done), 0);
      idle(3, 1);
      cyc(0, 0, 1, 1, 0, 0);
      check("b2b_done2", 32'(note_done), 1);
      idle(2, 1);

      // Reset mid-note with beats_left = 4, coincident with a beat.
      cyc(0, 1, 0, 1, 30, 6);
      idle(3, 1);
      cyc(0, 0, 1, 1, 0, 0);
      idle(3, 1);
      cyc(0, 0, 1, 1, 0, 0);
      check("mid_beats4", 32'(beats_left), 4);
      idle(3, 1);
      cyc(1, 0, 1, 1, 0, 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_done", 32'(note_done), 0);
      check("mid_rst_note", 32'(note_out), 0);
      for (int i = 0; i < 3; i++) begin
         idle(3, 1);
         cyc(0, 0, 1, 1, 0, 0);
         check("mid_ignored", 32'(beats_left), 0);
      end

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 99) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) != 0,
             int'($urandom_range(0, 63)),
             ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/beat_note_timer.md
# beat_note_timer

Consumes the 1-cycle beat tick produced by the beat generator (one pulse every 3,125,000 clocks, 32 beats/s at 100 MHz). It holds the current note for a programmed number of beats. The block sits between the song-reading logic, which loads note/duration pairs, and the tone generator, which plays `note_out` while `sounding` is high. It supports pause and signals note completion with a 1-cycle pulse, so upstream can issue notes back-to-back.

## Interface
- `NOTE_W`, default 6: note code width. Code 0 means rest/silence.
- `DUR_W`, default 6: duration width, in beats.
- `clock`, input, 1: system clock. All state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high. Clears all state on the next rising edge.
- `beat`, input, 1: 1-cycle tick from the beat generator. Never high on two consecutive cycles.
- `play`, input, 1: level signal. 1 = run, 0 = pause (freeze).
- `load`, input, 1: request to start a new note. Accepted only when `busy`=0.
- `note_in`, input, `NOTE_W`: note code sampled on an accepted load.
- `duration_in`, input, `DUR_W`: beat count sampled on an accepted load. Value 0 encodes 2^`DUR_W` (64 beats).
- `note_out`, output, `NOTE_W`: registered note being timed. 0 when idle.
- `sounding`, output, 1: `busy` & `play`. Combinational.
- `busy`, output, 1: registered. High while a note is being timed.
- `note_done`, output, 1: registered 1-cycle pulse marking the end of a note.
- `beats_left`, output, `DUR_W`+1: remaining beats in the current note. 0 when idle.

## Operation
- FSM has two states: IDLE (`busy`=0) and TIMING (`busy`=1).
- Reset values: state IDLE, `note_out`=0, `beats_left`=0, `note_done`=0, `busy`=0.
- IDLE, `load`=1:
  - Next cycle: TIMING, `note_out`=`note_in`.
  - `beats_left` = `duration_in`, or 2^`DUR_W` if `duration_in`=0.
- IDLE, `load`=0: hold all outputs.
- TIMING, `beat`=1 and `play`=1:
  - If `beats_left`>1: decrement `beats_left`.
  - If `beats_left`=1: next cycle IDLE, `beats_left`=0, `note_out`=0, `note_done`=1.
- TIMING, `beat`=0 or `play`=0: hold state. A beat arriving while paused is dropped, not queued.
- `load` while TIMING: ignored. The note in progress is unaffected.
- `note_done` is high for exactly one cycle. It is 0 on every other cycle.
- Back-to-back notes: `busy`=0 in the same cycle `note_done`=1. A `load` in that cycle is accepted. The next note starts in the following cycle with no gap cycle.
- Arithmetic: `beats_left` is unsigned, `DUR_W`+1 bits wide. It never wraps, never decrements below 1 while TIMING, and never exceeds 2^`DUR_W`.
- `reset` has priority over every other input, including mid-note and during a simultaneous `load` or `beat`. The cycle after reset shows all reset values and no `note_done` pulse.
- `play` toggling during IDLE has no effect on state. `sounding` stays 0.

## Timing
- Load latency is 1 cycle. With `load` at edge t, `busy`, `note_out` and `beats_left` are valid after edge t.
- Note length is N accepted beats (`beat`&`play` while TIMING).
- The final accepted beat is sampled at edge k. After edge k, `note_done`=1 and `busy`=0. After edge k+1, `note_done` returns to 0 unless a new note completes.
- A beat coincident with an accepted load (in IDLE) is not counted toward the new note.
- `sounding` follows `play` combinationally, with zero cycles of latency.

## Test plan
- **Reset:** hold `reset` 3 cycles with `load`=1, `beat`=1 → `note_out`=0, `busy`=0, `beats_left`=0, `note_done`=0 throughout and after release.
- **Basic note:** load `note_in`=17, `duration_in`=3, `play`=1, beats every 8 cycles.
  - Required: `beats_left` steps 3→2→1.
  - `note_done` pulses once, the cycle after the 3rd beat.
  - `note_out` returns to 0 at that point.
- **Pause:** `duration_in`=2, `play`=0 across 2 beats, then `play`=1.
  - Required: `beats_left` holds at 2 and `sounding`=0 while paused.
  - Completion occurs after 2 further beats.
- **Duration 0:** load `duration_in`=0 → `beats_left`=64, and `note_done` after exactly 64 beats.
- **Ignored load and back-to-back:**
  - `load` with `note_in`=5 mid-note → ignored; `note_out` unchanged.
  - `load` with `note_in`=9, `duration_in`=1 in the `note_done` cycle → accepted; `note_out`=9 the next cycle; `note_done` again after 1 beat.
- **Reset mid-note:** assert `reset` with `beats_left`=4 → all outputs return to reset values the next cycle, no `note_done` pulse, and beats are ignored until the next load.
